// File: rtl/call_button_panel.sv
// rtl/call_button_panel.sv - call button synchroniser, debouncer and lamp register
//
// Front end of the elevator controller. Raw hall/cab buttons are synchronised
// and debounced. Each accepted press latches a lamp and sends a one-cycle
// request pulse to the controller. A lamp clears once the car has dwelt at
// its floor.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   raw_buttons    asynchronous bouncy button levels, bit k = floor k+1
//   current_floor  floor reported by the controller, 1..FLOORS
//   going_up       controller status, not used by the datapath
//   going_down     controller status, not used by the datapath
//   busy           controller status, not used by the datapath
//   buttons        registered one-cycle request pulses
//   lamps          pending-call indicators
//   pending_count  popcount of lamps, registered with lamps
//
// Optional feature macro: CALL_REISSUE_EN. When defined, all lit lamps are
// re-pulsed on buttons every REISSUE_PERIOD cycles.
module call_button_panel #(
  parameter int FLOORS          = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DWELL_CYCLES    = 2,
  parameter int REISSUE_PERIOD  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] raw_buttons,
  input  logic [2:0]        current_floor,
  input  logic              going_up,
  input  logic              going_down,
  input  logic              busy,
  output logic [FLOORS-1:0] buttons,
  output logic [FLOORS-1:0] lamps,
  output logic [2:0]        pending_count
);

  logic [FLOORS-1:0] sync1;
  logic [FLOORS-1:0] s;
  logic [FLOORS-1:0] st;
  logic [FLOORS-1:0] st_d;
  logic [3:0]        cnt [FLOORS];

  logic [2:0]        prev_floor;
  logic [2:0]        dwell_cnt;
  logic [2:0]        dwell_cnt_next;
  logic              dwell_ok;

  logic [FLOORS-1:0] rise;
  logic [FLOORS-1:0] serve;
  logic [FLOORS-1:0] pulse;
  logic [FLOORS-1:0] lamps_next;
  logic [2:0]        lamps_next_count;
  logic [FLOORS-1:0] reissue_vec;

  // Direction and busy flags are status only.
  logic unused_status;
  assign unused_status = going_up ^ going_down ^ busy;

  always_comb begin
    // dwell_cnt holds how many consecutive cycles the floor had been stable
    // up to the previous cycle; the next value includes the present cycle,
    // so a floor held for DWELL_CYCLES cycles is served on the edge that
    // ends the last of them.
    dwell_cnt_next = 3'd1;
    if (current_floor == prev_floor) begin
      dwell_cnt_next = (dwell_cnt == 3'(DWELL_CYCLES)) ? dwell_cnt : dwell_cnt + 3'd1;
    end
    dwell_ok = (dwell_cnt_next == 3'(DWELL_CYCLES));

    rise = st & ~st_d;

    // Out-of-range floors (0 or above FLOORS) match no bit.
    serve = '0;
    for (int k = 0; k < FLOORS; k++) begin
      serve[k] = dwell_ok && (current_floor == 3'(k + 1));
    end

    // A press at the served floor still pulses; serve wins on the lamp.
    pulse      = rise & (serve | ~lamps);
    lamps_next = (lamps | rise) & ~serve;

    lamps_next_count = '0;
    for (int k = 0; k < FLOORS; k++) begin
      lamps_next_count = lamps_next_count + 3'(lamps_next[k]);
    end
  end

`ifdef CALL_REISSUE_EN
  localparam int RW = (REISSUE_PERIOD > 1) ? $clog2(REISSUE_PERIOD) : 1;

  logic [RW-1:0] reissue_timer;
  logic          reissue_wrap;

  assign reissue_wrap = (reissue_timer == RW'(REISSUE_PERIOD - 1));
  assign reissue_vec  = reissue_wrap ? lamps : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      reissue_timer <= '0;
    end else begin
      reissue_timer <= reissue_wrap ? '0 : reissue_timer + RW'(1);
    end
  end
`else
  localparam int unused_reissue_period = REISSUE_PERIOD;

  assign reissue_vec = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1         <= '0;
      s             <= '0;
      st            <= '0;
      st_d          <= '0;
      for (int k = 0; k < FLOORS; k++) begin
        cnt[k] <= '0;
      end
      prev_floor    <= '0;
      dwell_cnt     <= '0;
      buttons       <= '0;
      lamps         <= '0;
      pending_count <= '0;
    end else begin
      sync1 <= raw_buttons;
      s     <= sync1;
      st_d  <= st;

      // st only moves after DEBOUNCE_CYCLES consecutive differing samples.
      for (int k = 0; k < FLOORS; k++) begin
        if (s[k] == st[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == 4'(DEBOUNCE_CYCLES - 1)) begin
          st[k]  <= s[k];
          cnt[k] <= '0;
        end else begin
          cnt[k] <= cnt[k] + 4'd1;
        end
      end

      prev_floor    <= current_floor;
      dwell_cnt     <= dwell_cnt_next;
      buttons       <= pulse | reissue_vec;
      lamps         <= lamps_next;
      pending_count <= lamps_next_count;
    end
  end

endmodule

// File: tb/tb_call_button_panel.sv
// tb/tb_call_button_panel.sv - self-checking bench for call_button_panel
module tb_call_button_panel;

  localparam int FLOORS = 5;
  localparam int DB     = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [FLOORS-1:0] raw_buttons = '0;
  logic [2:0]        current_floor = '0;
  logic              going_up = 1'b0;
  logic              going_down = 1'b0;
  logic              busy = 1'b0;
  logic [FLOORS-1:0] buttons;
  logic [FLOORS-1:0] lamps;
  logic [2:0]        pending_count;

  always #5 clk = ~clk;

  call_button_panel #(
    .FLOORS(FLOORS), .DEBOUNCE_CYCLES(DB), .DWELL_CYCLES(2), .REISSUE_PERIOD(16)
  ) dut (
    .clk(clk), .reset(reset), .raw_buttons(raw_buttons),
    .current_floor(current_floor), .going_up(going_up),
    .going_down(going_down), .busy(busy), .buttons(buttons),
    .lamps(lamps), .pending_count(pending_count)
  );

  typedef struct {
    string             name;
    logic [FLOORS-1:0] raw;
    logic [2:0]        floor;
    int                cycles;
    logic [FLOORS-1:0] exp_lamps;
    int                exp_npulse;
    logic [FLOORS-1:0] exp_pvec;
  } vec_t;

  typedef struct {
    string             name;
    logic [FLOORS-1:0] lamps;
    logic [2:0]        pc;
    int                npulse;
    logic [FLOORS-1:0] pvec;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int npulse;
  logic [FLOORS-1:0] pvec;
  int first_pulse;
  int last_pulse;
  int base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    npulse = 0;
    pvec = '0;
    first_pulse = -1;
    last_pulse = -1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (buttons !== '0) begin
      npulse++;
      pvec |= buttons;
      if (first_pulse < 0) first_pulse = cyc;
      last_pulse = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic void add(input string name, input logic [FLOORS-1:0] raw,
                              input logic [2:0] floor, input int cycles,
                              input logic [FLOORS-1:0] el, input int np,
                              input logic [FLOORS-1:0] pv);
    vec_t v;
    v.name = name; v.raw = raw; v.floor = floor; v.cycles = cycles;
    v.exp_lamps = el; v.exp_npulse = np; v.exp_pvec = pv;
    tbl.push_back(v);
  endfunction

  task automatic apply_vec(input vec_t v);
    exp_t e;
    e.name = v.name;
    e.lamps = v.exp_lamps;
    e.pc = 3'($countones(v.exp_lamps));
    e.npulse = v.exp_npulse;
    e.pvec = v.exp_pvec;
    sb.push_back(e);
    raw_buttons = v.raw;
    current_floor = v.floor;
    clear_mon();
    run(v.cycles);
    e = sb.pop_front();
    check({e.name, ".lamps"}, 32'(lamps), 32'(e.lamps));
    check({e.name, ".pending_count"}, 32'(pending_count), 32'(e.pc));
    check({e.name, ".pulses"}, 32'(npulse), 32'(e.npulse));
    check({e.name, ".pulse_vec"}, 32'(pvec), 32'(e.pvec));
  endtask

  task automatic hand_check(input string name, input logic [FLOORS-1:0] el);
    check({name, ".lamps"}, 32'(lamps), 32'(el));
    check({name, ".pending_count"}, 32'(pending_count), 32'($countones(el)));
  endtask

  initial begin
    // name, raw, floor, cycles, lamps, pulses, pulse vector
    add("serve_f1",        5'b00000, 3'd1, 4,  5'b11110, 0, 5'b00000);
    add("serve_f2",        5'b00000, 3'd2, 4,  5'b11100, 0, 5'b00000);
    add("serve_f3",        5'b00000, 3'd3, 4,  5'b11000, 0, 5'b00000);
    add("serve_f4",        5'b00000, 3'd4, 4,  5'b10000, 0, 5'b00000);
    add("serve_f5",        5'b00000, 3'd5, 4,  5'b00000, 0, 5'b00000);
    add("glitch",          5'b00100, 3'd0, 3,  5'b00000, 0, 5'b00000);
    add("glitch_gap",      5'b00000, 3'd0, 8,  5'b00000, 0, 5'b00000);
    add("press_f3",        5'b00100, 3'd0, 10, 5'b00100, 1, 5'b00100);
    add("hold_f3",         5'b00100, 3'd0, 10, 5'b00100, 0, 5'b00000);
    add("press_f4",        5'b01100, 3'd0, 10, 5'b01100, 1, 5'b01000);
    add("release",         5'b00000, 3'd0, 10, 5'b01100, 0, 5'b00000);
    add("repress_f4",      5'b01000, 3'd0, 10, 5'b01100, 0, 5'b00000);
    add("release_f4",      5'b00000, 3'd0, 10, 5'b01100, 0, 5'b00000);
    add("serve_f3b",       5'b00000, 3'd3, 4,  5'b01000, 0, 5'b00000);
    add("press_f2",        5'b00010, 3'd0, 10, 5'b01010, 1, 5'b00010);
    add("release_f2",      5'b00000, 3'd0, 10, 5'b01010, 0, 5'b00000);
    add("press_f1_f5",     5'b10001, 3'd0, 10, 5'b10001, 1, 5'b10001);
    add("release_multi",   5'b00000, 3'd0, 10, 5'b10001, 0, 5'b00000);
    add("floor0_hold",     5'b00000, 3'd0, 5,  5'b10001, 0, 5'b00000);
    add("floor6_hold",     5'b00000, 3'd6, 5,  5'b10001, 0, 5'b00000);
    add("floor7_hold",     5'b00000, 3'd7, 5,  5'b10001, 0, 5'b00000);
    add("dwell_f3",        5'b00000, 3'd3, 4,  5'b10001, 0, 5'b00000);
    add("press_at_dwell",  5'b00100, 3'd3, 10, 5'b10001, 1, 5'b00100);
    add("release_dwell",   5'b00000, 3'd3, 10, 5'b10001, 0, 5'b00000);

    // Reset held with all buttons pressed, then released with them held.
    reset = 1'b0;
    raw_buttons = 5'b11111;
    current_floor = 3'd0;
    clear_mon();
    run(3);
    check("reset.buttons", 32'(buttons), 32'd0);
    hand_check("reset", 5'b00000);
    check("reset.pulses", 32'(npulse), 32'd0);
    reset = 1'b1;
    base = cyc;
    clear_mon();
    run(12);
    check("release.latency", 32'(first_pulse - base - 1), 32'(DB + 2));
    check("release.pulses", 32'(npulse), 32'd1);
    check("release.pulse_vec", 32'(pvec), 32'(5'b11111));
    hand_check("release", 5'b11111);

`ifndef CALL_REISSUE_EN
    for (int i = 0; i < 16; i++) apply_vec(tbl[i]);

    // Exact dwell timing: a floor is served on its second consecutive cycle.
    current_floor = 3'd1; step();
    current_floor = 3'd2; step();
    hand_check("dwell_f2_first", 5'b01010);
    step();
    hand_check("dwell_f2_second", 5'b01000);
    current_floor = 3'd3; step();
    current_floor = 3'd4; step();
    hand_check("dwell_f4_first", 5'b01000);
    step();
    hand_check("dwell_f4_second", 5'b00000);

    for (int i = 16; i < tbl.size(); i++) apply_vec(tbl[i]);

    // Reset landing on the edge that would register the pulse discards it.
    current_floor = 3'd0;
    raw_buttons = 5'b00010;
    clear_mon();
    run(6);
    reset = 1'b0;
    raw_buttons = 5'b00000;
    step();
    reset = 1'b1;
    run(12);
    check("midpulse_reset.pulses", 32'(npulse), 32'd0);
    hand_check("midpulse_reset", 5'b00000);
`else
    raw_buttons = 5'b00000;
    current_floor = 3'd2; run(4);
    current_floor = 3'd3; run(4);
    current_floor = 3'd4; run(4);
    current_floor = 3'd0; run(2);
    hand_check("reissue_setup", 5'b10001);
    clear_mon();
    run(64);
    check("reissue.pulses", 32'(npulse), 32'd4);
    check("reissue.pulse_vec", 32'(pvec), 32'(5'b10001));
    check("reissue.spacing", 32'(last_pulse - first_pulse), 32'd48);
    current_floor = 3'd1; run(4);
    current_floor = 3'd5; run(4);
    current_floor = 3'd0; run(2);
    clear_mon();
    run(40);
    check("reissue_stop.pulses", 32'(npulse), 32'd0);
    hand_check("reissue_stop", 5'b00000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/call_button_panel.md
Name: call_button_panel

Overview:
- Front-end stage that sits directly upstream of the elevator controller.
- Synchronises and debounces the raw hall/cab call buttons, then latches each accepted call into a lamp register.
- Issues one registered one-cycle pulse per accepted press on `buttons`, which feeds the controller's `buttons` input.
- Clears a lamp when the car is seen dwelling at that floor. `current_floor`, `going_up`, `going_down` and `busy` come back from the controller.

Parameters:
- FLOORS, 5, number of floors; bit k corresponds to floor k+1.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a level change (legal range 1..15).
- DWELL_CYCLES, 2, consecutive cycles `current_floor` must hold one value before that floor counts as served (legal range 2..7).
- REISSUE_PERIOD, 16, cycles between re-pulses of an unserved call (only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- raw_buttons  in  FLOORS  asynchronous, bouncy button levels; 1 = pressed.
- current_floor  in  3  floor number from the controller, 1..FLOORS.
- going_up  in  1  controller direction flag (status only).
- going_down  in  1  controller direction flag (status only).
- busy  in  1  controller busy flag (status only).
- buttons  out  FLOORS  registered one-cycle request pulses to the controller.
- lamps  out  FLOORS  pending-call indicators.
- pending_count  out  3  population count of `lamps`.

Behaviour:
- Reset:
  - Sampled at a rising clk edge with reset==0.
  - Clears sync flops, debounce counters, stable levels, `buttons`, `lamps`, `pending_count`, the dwell counter and the reissue timer.
  - Reset asserted mid-debounce or mid-pulse discards everything; nothing is emitted afterwards for that press until a fresh accepted rising edge.
- Synchroniser: two-flop synchroniser per bit, producing `s[k]`.
- Debouncer:
  - Per bit: a stable level `st[k]` and a counter `cnt[k]`.
  - If `s[k]`==`st[k]`, `cnt` is cleared.
  - Otherwise `cnt` increments; when it reaches DEBOUNCE_CYCLES-1 and `s[k]` still differs, `st[k]` takes `s[k]` and `cnt` clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes `st`.
- Latency: `raw_buttons[k]` rising before edge E0 and held steady gives `st[k]` rising at edge E0+1+DEBOUNCE_CYCLES, and `buttons[k]` high for exactly the cycle following edge E0+2+DEBOUNCE_CYCLES.
- Accept (on a 0→1 transition of `st[k]`):
  - Case A, floor k+1 is the current dwell floor (dwell_ok and `current_floor`==k+1): pulse `buttons[k]`; lamp stays 0.
  - Case B, `lamps[k]` already 1: no pulse, no change.
  - Otherwise: set `lamps[k]` and pulse `buttons[k]` in the same cycle.
  - A 1→0 transition of `st[k]` has no effect.
  - Several floors accepted on the same edge pulse together in one vector.
- Dwell tracking:
  - A 3-bit dwell counter compares `current_floor` with its value on the previous cycle.
  - Equal: the counter increments, saturating at DWELL_CYCLES.
  - Different: the counter resets to 1.
  - dwell_ok = (counter == DWELL_CYCLES).
- Serve:
  - While dwell_ok and `current_floor` is in 1..FLOORS, `lamps[current_floor-1]` clears on the next edge.
  - If serve and accept hit the same bit on the same edge, serve wins: the lamp ends at 0 and the pulse is still emitted.
  - `current_floor` values of 0 or >FLOORS never clear a lamp and are not an error.
- `pending_count` is registered and updates on the same edge as `lamps`, so it always equals popcount(`lamps`).
- `going_up`, `going_down` and `busy` do not affect datapath behaviour.

Optional Feature:
- Macro: CALL_REISSUE_EN.
- Defined:
  - A free-running counter of width clog2(REISSUE_PERIOD) wraps every REISSUE_PERIOD cycles.
  - On each wrap, `buttons` pulses for one cycle with the value `lamps` held before that edge.
  - This recovers calls the controller dropped.
  - If a wrap coincides with an accept, the pulse vector is the OR of both.
- Undefined: the timer is absent, and `buttons` pulses only on accepts.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with raw_buttons=5'b11111 → `buttons`=0, `lamps`=0, `pending_count`=0. Release reset with raw held → `lamps`=5'b11111 and a single `buttons` pulse 5'b11111 exactly DEBOUNCE_CYCLES+2 cycles after the first edge with reset=1.
- Glitch rejection: pulse raw_buttons[2] high for 3 cycles (DEBOUNCE_CYCLES=4) → no pulse, `lamps`=0. Hold it high for 10 cycles → one `buttons`=5'b00100 pulse, `lamps`=5'b00100, `pending_count`=1, and no second pulse while held.
- Duplicate suppression: with `lamps[3]`=1, release and re-press raw_buttons[3] → no `buttons` pulse and `lamps` unchanged.
- Serve: lamps=5'b01010; drive `current_floor` 1,2,2 → after the 2nd cycle at 2, `lamps`=5'b01000. Drive `current_floor` 3,4 (1 cycle each) → floor 4 is not yet cleared. Hold 4 for a 2nd cycle → `lamps`=0.
- Press at dwell floor: `current_floor` held at 3, press floor 3 → `buttons`=5'b00100 pulse and `lamps[2]` stays 0. Also drive `current_floor`=0 for 5 cycles with lamps=5'b00001 → `lamps` unchanged.
- CALL_REISSUE_EN: lamps=5'b10001, no presses → `buttons`=5'b10001 for one cycle every 16 cycles. Clear via serve → pulses stop.
